pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 196 +++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, filters the synchronized lock,
// and holds downstream logic in reset until lock has been stable for a settle delay.
//
// state       | meaning
// ASSERT_RST  | PLL reset pin driven high for the pulse width
// WAIT_LOCK   | PLL released, waiting for lock_s, timeout running
// FILTER      | lock_s seen, counting consecutive high cycles
// RELEASE_DLY | lock accepted, settle delay before releasing sys_reset
// RUN         | system out of reset, locked
// FAULT       | retries exhausted, waits for reset or relock_req
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES     = 16,
    parameter int LOCK_FILTER_CYCLES   = 64,
    parameter int LOCK_TIMEOUT_CYCLES  = 500000,
    parameter int RELEASE_DELAY_CYCLES = 256,
    parameter int MAX_RETRIES          = 3,
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clkin,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               locked,
    output logic               fault,
    output logic               lost_lock,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int RST_W = (RST_PULSE_CYCLES > 1)     ? $clog2(RST_PULSE_CYCLES)     : 1;
    localparam int FLT_W = (LOCK_FILTER_CYCLES > 1)   ? $clog2(LOCK_FILTER_CYCLES)   : 1;
    localparam int TMO_W = (LOCK_TIMEOUT_CYCLES > 1)  ? $clog2(LOCK_TIMEOUT_CYCLES)  : 1;
    localparam int REL_W = (RELEASE_DELAY_CYCLES > 1) ? $clog2(RELEASE_DELAY_CYCLES) : 1;

    localparam logic [RST_W-1:0]   RST_TC      = RST_W'(RST_PULSE_CYCLES - 1);
    localparam logic [FLT_W-1:0]   FLT_TC      = FLT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_TC      = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [REL_W-1:0]   REL_TC      = REL_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ASSERT_RST,
        WAIT_LOCK,
        FILTER,
        RELEASE_DLY,
        RUN,
        FAULT
    } state_e;

    state_e             state_q, state_d;
    logic               lock_meta_q, lock_s_q;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d, rst_inc;
    logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d, flt_inc;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d, rel_inc;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic               lost_lock_q, lost_lock_d;
    logic               pll_reset_q, pll_reset_d;
    logic               sys_reset_q, sys_reset_d;
    logic               locked_q, locked_d;
    logic               fault_q, fault_d;
    logic               timeout;

    assign rst_inc = (rst_cnt_q == '1) ? rst_cnt_q : rst_cnt_q + 1'b1;
    assign flt_inc = (flt_cnt_q == '1) ? flt_cnt_q : flt_cnt_q + 1'b1;
    assign tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    assign rel_inc = (rel_cnt_q == '1) ? rel_cnt_q : rel_cnt_q + 1'b1;
    assign timeout = (tmo_cnt_q >= TMO_TC);

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        flt_cnt_d   = flt_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        retry_cnt_d = retry_cnt_q;
        lost_lock_d = lost_lock_q;

        if (relock_req) begin
            state_d   = ASSERT_RST;
            rst_cnt_d = '0;
            if (state_q != ASSERT_RST) begin
                retry_cnt_d = '0;
            end
        end else begin
            case (state_q)
                ASSERT_RST: begin
                    if (rst_cnt_q >= RST_TC) begin
                        state_d   = WAIT_LOCK;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_inc;
                    end
                end
                WAIT_LOCK, FILTER: begin
                    // The timeout window spans both states; it is only cleared on a fresh PLL reset.
                    tmo_cnt_d = tmo_inc;
                    if (state_q == FILTER && !lock_s_q) begin
                        state_d = WAIT_LOCK;
                    end else if (state_q == WAIT_LOCK && lock_s_q) begin
                        state_d   = FILTER;
                        flt_cnt_d = '0;
                    end else if (timeout) begin
                        if (retry_cnt_q >= MAX_RETRY_V) begin
                            state_d = FAULT;
                        end else begin
                            state_d     = ASSERT_RST;
                            rst_cnt_d   = '0;
                            retry_cnt_d = retry_cnt_q + 1'b1;
                        end
                    end else if (state_q == FILTER) begin
                        if (flt_inc >= FLT_TC) begin
                            state_d   = RELEASE_DLY;
                            rel_cnt_d = '0;
                        end else begin
                            flt_cnt_d = flt_inc;
                        end
                    end
                end
                RELEASE_DLY: begin
                    if (!lock_s_q) begin
                        state_d     = ASSERT_RST;
                        rst_cnt_d   = '0;
                        lost_lock_d = 1'b1;
                    end else if (rel_cnt_q >= REL_TC) begin
                        state_d     = RUN;
                        retry_cnt_d = '0;
                    end else begin
                        rel_cnt_d = rel_inc;
                    end
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_d     = ASSERT_RST;
                        rst_cnt_d   = '0;
                        lost_lock_d = 1'b1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d   = ASSERT_RST;
                    rst_cnt_d = '0;
                end
            endcase
        end

        // Outputs decode the next state so they register in the same cycle as the transition.
        pll_reset_d = (state_d == ASSERT_RST) || (state_d == FAULT);
        sys_reset_d = (state_d != RUN);
        locked_d    = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ASSERT_RST;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            rst_cnt_q   <= '0;
            flt_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            retry_cnt_q <= '0;
            lost_lock_q <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            rst_cnt_q   <= rst_cnt_d;
            flt_cnt_q   <= flt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            lost_lock_q <= lost_lock_d;
            pll_reset_q <= pll_reset_d;
            sys_reset_q <= sys_reset_d;
            locked_q    <= locked_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_reset = sys_reset_q;
    assign locked    = locked_q;
    assign fault     = fault_q;
    assign lost_lock = lost_lock_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_reset;
    logic       locked;
    logic       fault;
    logic       lost_lock;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_FILTER_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (100),
        .RELEASE_DELAY_CYCLES(16),
        .MAX_RETRIES         (2)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_reset (pll_reset),
        .sys_reset (sys_reset),
        .locked    (locked),
        .fault     (fault),
        .lost_lock (lost_lock),
        .retry_cnt (retry_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic pr, input logic sr, input logic lk,
                           input logic ft, input logic ll, input logic [1:0] rc);
        chk({tag, ".pll_reset"}, 32'(pll_reset), 32'(pr));
        chk({tag, ".sys_reset"}, 32'(sys_reset), 32'(sr));
        chk({tag, ".locked"},    32'(locked),    32'(lk));
        chk({tag, ".fault"},     32'(fault),     32'(ft));
        chk({tag, ".lost_lock"}, 32'(lost_lock), 32'(ll));
        chk({tag, ".retry_cnt"}, 32'(retry_cnt), 32'(rc));
    endtask

    // Advance n cycles, requiring pll_reset to equal exp after every edge.
    task automatic hold_pr(input string tag, input logic exp, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk(tag, 32'(pll_reset), 32'(exp));
        end
    endtask

    // Advance n cycles, requiring sys_reset to stay asserted after every edge.
    task automatic hold_sr(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            chk(tag, 32'(sys_reset), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        step(3);
        chk_all("reset", 1, 1, 0, 0, 0, 0);

        // Nominal lock: lock raised 20 cycles after pll_reset falls, release 26 cycles later.
        reset = 1'b0;
        hold_pr("s1_pulse_hi", 1, 3);
        hold_pr("s1_pulse_lo", 0, 1);
        step(20);
        pll_lock = 1'b1;
        step(25);
        chk("s1_sys_reset_before", 32'(sys_reset), 32'd1);
        chk("s1_locked_before", 32'(locked), 32'd0);
        step(1);
        chk_all("s1_run", 0, 0, 1, 0, 0, 0);

        // relock_req in RUN.
        step(3);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk_all("s5_relock", 1, 1, 0, 0, 0, 0);
        hold_pr("s5_pulse_hi", 1, 3);
        hold_pr("s5_pulse_lo", 0, 1);
        step(23);
        chk("s5_sys_reset_before", 32'(sys_reset), 32'd1);
        step(1);
        chk_all("s5_run", 0, 0, 1, 0, 0, 0);

        // One-cycle lock drop in RUN.
        step(4);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        chk("s4_locked_d1", 32'(locked), 32'd1);
        step(1);
        chk("s4_locked_d2", 32'(locked), 32'd1);
        step(1);
        chk_all("s4_loss", 1, 1, 0, 0, 1, 0);
        hold_pr("s4_pulse_hi", 1, 3);
        hold_pr("s4_pulse_lo", 0, 1);
        step(23);
        chk("s4_sys_reset_before", 32'(sys_reset), 32'd1);
        step(1);
        chk_all("s4_run", 0, 0, 1, 0, 1, 0);

        // Glitchy lock: 5 high, 3 low, then steady.
        reset    = 1'b1;
        pll_lock = 1'b0;
        step(1);
        chk_all("s2_reset", 1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        hold_pr("s2_pulse_hi", 1, 3);
        hold_pr("s2_pulse_lo", 0, 1);
        step(5);
        pll_lock = 1'b1;
        hold_sr("s2_glitch_hi", 5);
        pll_lock = 1'b0;
        hold_sr("s2_glitch_lo", 3);
        pll_lock = 1'b1;
        hold_sr("s2_settle", 25);
        step(1);
        chk_all("s2_run", 0, 0, 1, 0, 0, 0);

        // Never lock: three pulses 100 cycles apart, then FAULT.
        reset    = 1'b1;
        pll_lock = 1'b0;
        step(1);
        reset = 1'b0;
        hold_pr("s3_p1_hi", 1, 3);
        hold_pr("s3_p1_lo", 0, 100);
        hold_pr("s3_p2_hi", 1, 4);
        chk("s3_retry1", 32'(retry_cnt), 32'd1);
        hold_pr("s3_p2_lo", 0, 100);
        hold_pr("s3_p3_hi", 1, 4);
        chk("s3_retry2", 32'(retry_cnt), 32'd2);
        hold_pr("s3_p3_lo", 0, 100);
        step(1);
        chk_all("s3_fault", 1, 1, 0, 1, 0, 2);
        step(5);
        chk_all("s3_fault_hold", 1, 1, 0, 1, 0, 2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        chk_all("s3_relock", 1, 1, 0, 0, 0, 0);
        step(1);
        chk("s3_pulse_mid", 32'(pll_reset), 32'd1);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        hold_pr("s3_restart_hi", 1, 3);
        hold_pr("s3_restart_lo", 0, 1);

        // Reset mid-FILTER, then mid-RELEASE_DLY, then a full sequence.
        pll_lock = 1'b1;
        step(5);
        chk("s6_in_filter", 32'(pll_reset), 32'd0);
        reset = 1'b1;
        step(1);
        chk_all("s6_rst_filter", 1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        hold_pr("s6_a_pulse_hi", 1, 3);
        hold_pr("s6_a_pulse_lo", 0, 1);
        step(11);
        chk("s6_in_release", 32'(sys_reset), 32'd1);
        reset = 1'b1;
        step(1);
        chk_all("s6_rst_release", 1, 1, 0, 0, 0, 0);
        reset = 1'b0;
        hold_pr("s6_b_pulse_hi", 1, 3);
        hold_pr("s6_b_pulse_lo", 0, 1);
        step(23);
        chk("s6_sys_reset_before", 32'(sys_reset), 32'd1);
        step(1);
        chk_all("s6_run", 0, 0, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
